reg_rename_file: RTL and testbench

Parametrised architectural register file with per-register rename status (busy bit plus reorder-buffer tag), serving the out-of-order core's decode/issue stage. Replaces the fixed 32×32 register/tag store with configurable width, depth, tag width and read-port count. Adds tag-qualified commit, global flush on misprediction, a live busy-register counter and optional same-cycle commit-to-read bypass.

---
 rtl/reg_rename_file_pkg.sv | 25 ++
 rtl/rf_read_port.sv | 68 ++++++
 rtl/reg_rename_file.sv | 134 +++++++++++++
 tb/tb_reg_rename_file.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_rename_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_rename_file_pkg
// Description : Shared widths, typedefs and constants for the register
//               rename file and its read ports.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_rename_file_pkg;

  // Default configuration of the register/tag store
  localparam int unsigned C_XLEN_DEF  = 32;
  localparam int unsigned C_NREG_DEF  = 32;
  localparam int unsigned C_TAG_W_DEF = 4;
  localparam int unsigned C_NRD_DEF   = 2;
  localparam int unsigned C_IDX_W_DEF = $clog2(C_NREG_DEF);

  typedef logic [C_IDX_W_DEF-1:0] reg_idx_t;
  typedef logic [C_TAG_W_DEF-1:0] rob_tag_t;
  typedef logic [C_XLEN_DEF-1:0]  xlen_word_t;

  // Hardwired-zero architectural register
  localparam reg_idx_t C_REG_ZERO = '0;

endpackage : reg_rename_file_pkg
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ============================================================================
// Module      : rf_read_port
// Description : One combinational read port of the rename file. Selects
//               value, busy bit and ROB tag for a register index; x0 always
//               reads as zero / not busy. With REGFILE_BYPASS_EN defined, a
//               same-cycle commit to the read index is forwarded.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_read_port
  import reg_rename_file_pkg::*;
#(
  parameter int unsigned XLEN  = C_XLEN_DEF,
  parameter int unsigned NREG  = C_NREG_DEF,
  parameter int unsigned TAG_W = C_TAG_W_DEF
) (
  input  logic [$clog2(NREG)-1:0] idx_i,
  input  logic [XLEN-1:0]         regs_i [NREG],
  input  logic [NREG-1:0]         busy_i,
  input  logic [TAG_W-1:0]        tags_i [NREG],
  input  logic                    byp_en_i,
  input  logic [$clog2(NREG)-1:0] cmt_rd_i,
  input  logic [TAG_W-1:0]        cmt_tag_i,
  input  logic [XLEN-1:0]         cmt_val_i,
  output logic [XLEN-1:0]         val_o,
  output logic                    busy_o,
  output logic [TAG_W-1:0]        tag_o
);

  localparam int unsigned IDX_W = $clog2(NREG);

  logic [XLEN-1:0]  w_val;
  logic             w_busy;
  logic [TAG_W-1:0] w_tag;

`ifndef REGFILE_BYPASS_EN
  // Commit inputs only matter when forwarding is built in
  logic w_unused_byp;
  assign w_unused_byp = ^{byp_en_i, cmt_rd_i, cmt_tag_i, cmt_val_i};
`endif

  // Select registered state, optionally forward a same-cycle commit, mask x0
  always_comb begin
    w_val  = regs_i[idx_i];
    w_busy = busy_i[idx_i];
    w_tag  = tags_i[idx_i];
`ifdef REGFILE_BYPASS_EN
    // byp_en_i already excludes x0 and idle/stalled cycles
    if (byp_en_i && (idx_i == cmt_rd_i)) begin
      w_val = cmt_val_i;
      if (w_busy && (w_tag == cmt_tag_i)) begin
        w_busy = 1'b0;
      end
    end
`endif
    if (idx_i == IDX_W'(C_REG_ZERO)) begin
      w_val  = '0;
      w_busy = 1'b0;
      w_tag  = '0;
    end
  end

  assign val_o  = w_val;
  assign busy_o = w_busy;
  assign tag_o  = w_tag;

endmodule : rf_read_port
`default_nettype wire

// File: rtl/reg_rename_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_rename_file
// Description : Architectural register file with per-register rename state
//               (busy bit + ROB tag), tag-qualified commit, global flush,
//               live busy-register counter and NRD combinational read ports.
//               Optional feature macro: REGFILE_BYPASS_EN (commit-to-read
//               forwarding inside each read port).
// Revision    : 1.0 - initial release
// ============================================================================
module reg_rename_file
  import reg_rename_file_pkg::*;
#(
  parameter int unsigned XLEN  = C_XLEN_DEF,
  parameter int unsigned NREG  = C_NREG_DEF,
  parameter int unsigned TAG_W = C_TAG_W_DEF,
  parameter int unsigned NRD   = C_NRD_DEF
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        ren_valid,
  input  logic [$clog2(NREG)-1:0]     ren_rd,
  input  logic [TAG_W-1:0]            ren_tag,
  input  logic                        cmt_valid,
  input  logic [$clog2(NREG)-1:0]     cmt_rd,
  input  logic [TAG_W-1:0]            cmt_tag,
  input  logic [XLEN-1:0]             cmt_val,
  input  logic                        flush_in,
  input  logic [NRD*$clog2(NREG)-1:0] rd_idx,
  output logic [NRD*XLEN-1:0]         rd_val,
  output logic [NRD-1:0]              rd_busy,
  output logic [NRD*TAG_W-1:0]        rd_tag,
  output logic [$clog2(NREG):0]       busy_cnt
);

  localparam int unsigned IDX_W = $clog2(NREG);

  logic [XLEN-1:0]  regs_q [NREG];
  logic [NREG-1:0]  busy_q, busy_d;
  logic [TAG_W-1:0] tag_q  [NREG];
  logic [TAG_W-1:0] tag_d  [NREG];
  logic [IDX_W:0]   cnt_q, cnt_d;

  logic w_flush;
  logic w_cmt_ok;
  logic w_ren_ok;
  logic w_cmt_match;
  logic w_same_rd;
  logic w_cnt_inc;
  logic w_cnt_dec;

  // Qualified requests: nothing acts while stalled, x0 is never a target,
  // and a flush squashes the rename issued alongside it
  assign w_flush     = rdy_in & flush_in;
  assign w_cmt_ok    = rdy_in & cmt_valid & (cmt_rd != IDX_W'(C_REG_ZERO));
  assign w_ren_ok    = rdy_in & ren_valid & ~flush_in & (ren_rd != IDX_W'(C_REG_ZERO));
  assign w_cmt_match = w_cmt_ok & busy_q[cmt_rd] & (tag_q[cmt_rd] == cmt_tag);
  assign w_same_rd   = w_ren_ok & (ren_rd == cmt_rd);
  // A re-rename of a busy register and a matching commit overridden by a
  // rename of the same register both leave the population unchanged
  assign w_cnt_inc   = w_ren_ok & ~busy_q[ren_rd];
  assign w_cnt_dec   = w_cmt_match & ~w_same_rd;

  // Next rename state: commit clears first, rename then overrides
  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    cnt_d  = cnt_q;
    if (w_flush) begin
      busy_d = '0;
      cnt_d  = '0;
    end else begin
      if (w_cmt_match) begin
        busy_d[cmt_rd] = 1'b0;
      end
      if (w_ren_ok) begin
        busy_d[ren_rd] = 1'b1;
        tag_d[ren_rd]  = ren_tag;
      end
      cnt_d = cnt_q + (IDX_W+1)'(w_cnt_inc) - (IDX_W+1)'(w_cnt_dec);
    end
  end

  // Register values: every qualified commit writes, even stale or flushed ones
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else if (w_cmt_ok) begin
      regs_q[cmt_rd] <= cmt_val;
    end
  end

  // Rename state and busy counter
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < int'(NREG); i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      tag_q  <= tag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  for (genvar k = 0; k < int'(NRD); k++) begin : g_rd_port
    rf_read_port #(
      .XLEN  (XLEN),
      .NREG  (NREG),
      .TAG_W (TAG_W)
    ) u_rd_port (
      .idx_i     (rd_idx[k*IDX_W +: IDX_W]),
      .regs_i    (regs_q),
      .busy_i    (busy_q),
      .tags_i    (tag_q),
      .byp_en_i  (w_cmt_ok),
      .cmt_rd_i  (cmt_rd),
      .cmt_tag_i (cmt_tag),
      .cmt_val_i (cmt_val),
      .val_o     (rd_val[k*XLEN +: XLEN]),
      .busy_o    (rd_busy[k]),
      .tag_o     (rd_tag[k*TAG_W +: TAG_W])
    );
  end

endmodule : reg_rename_file
`default_nettype wire

// File: tb/tb_reg_rename_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_rename_file
// Description : Self-checking bench for reg_rename_file (default sizes).
//               Stimulus pushes expected read-port state into a queue; a
//               monitor pops and compares against the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_rename_file;
  import reg_rename_file_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned NRD   = 2;
  localparam int unsigned IDX_W = 5;

  logic                   clk_in;
  logic                   rst_in;
  logic                   rdy_in;
  logic                   ren_valid;
  logic [IDX_W-1:0]       ren_rd;
  logic [TAG_W-1:0]       ren_tag;
  logic                   cmt_valid;
  logic [IDX_W-1:0]       cmt_rd;
  logic [TAG_W-1:0]       cmt_tag;
  logic [XLEN-1:0]        cmt_val;
  logic                   flush_in;
  logic [NRD*IDX_W-1:0]   rd_idx;
  logic [NRD*XLEN-1:0]    rd_val;
  logic [NRD-1:0]         rd_busy;
  logic [NRD*TAG_W-1:0]   rd_tag;
  logic [IDX_W:0]         busy_cnt;

  reg_rename_file #(
    .XLEN  (XLEN),
    .NREG  (NREG),
    .TAG_W (TAG_W),
    .NRD   (NRD)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .ren_valid (ren_valid),
    .ren_rd    (ren_rd),
    .ren_tag   (ren_tag),
    .cmt_valid (cmt_valid),
    .cmt_rd    (cmt_rd),
    .cmt_tag   (cmt_tag),
    .cmt_val   (cmt_val),
    .flush_in  (flush_in),
    .rd_idx    (rd_idx),
    .rd_val    (rd_val),
    .rd_busy   (rd_busy),
    .rd_tag    (rd_tag),
    .busy_cnt  (busy_cnt)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    string            name;
    int               port;
    logic [XLEN-1:0]  val;
    logic             busy;
    logic [TAG_W-1:0] tag;
    logic [IDX_W:0]   cnt;
  } exp_t;

  exp_t exp_q[$];
  int   push_cnt = 0;
  int   pop_cnt  = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Monitor: compare the DUT outputs against each queued expectation
  initial begin
    exp_t             e;
    logic [XLEN-1:0]  gv;
    logic             gb;
    logic [TAG_W-1:0] gt;
    forever begin
      wait (push_cnt != pop_cnt);
      e  = exp_q.pop_front();
      pop_cnt++;
      gv = rd_val[e.port*XLEN +: XLEN];
      gb = rd_busy[e.port];
      gt = rd_tag[e.port*TAG_W +: TAG_W];
      n_checks++;
      if ((gv === e.val) && (gb === e.busy) && (!e.busy || (gt === e.tag)) &&
          (busy_cnt === e.cnt)) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got val=%h busy=%b tag=%h cnt=%0d, want val=%h busy=%b tag=%h cnt=%0d",
                 e.name, gv, gb, gt, busy_cnt, e.val, e.busy, e.tag, e.cnt);
      end
    end
  end

  task automatic idle();
    ren_valid = 1'b0; ren_rd = '0; ren_tag = '0;
    cmt_valid = 1'b0; cmt_rd = '0; cmt_tag = '0; cmt_val = '0;
    flush_in  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic rename(input reg_idx_t rd, input rob_tag_t tg);
    ren_valid = 1'b1; ren_rd = rd; ren_tag = tg;
  endtask

  task automatic commit(input reg_idx_t rd, input rob_tag_t tg, input xlen_word_t v);
    cmt_valid = 1'b1; cmt_rd = rd; cmt_tag = tg; cmt_val = v;
  endtask

  task automatic chk(input string nm, input int port, input reg_idx_t idx,
                     input xlen_word_t v, input logic b, input rob_tag_t t,
                     input logic [IDX_W:0] c);
    rd_idx[port*IDX_W +: IDX_W] = idx;
    #1;
    exp_q.push_back('{nm, port, v, b, t, c});
    push_cnt++;
    #1;
  endtask

  initial begin
    rst_in = 1'b0;
    rdy_in = 1'b1;
    rd_idx = '0;
    idle();

    // Asynchronous reset, observed before any clock edge
    #2 rst_in = 1'b1;
    chk("reset_x0",  0, 5'd0,  32'h0, 1'b0, 4'h0, 6'd0);
    chk("reset_x5",  1, 5'd5,  32'h0, 1'b0, 4'h0, 6'd0);
    chk("reset_x31", 0, 5'd31, 32'h0, 1'b0, 4'h0, 6'd0);
    rst_in = 1'b0;
    tick();

    // Rename then matching commit
    rename(5'd5, 4'd3); tick(); idle();
    chk("rename_x5", 0, 5'd5, 32'h0, 1'b1, 4'd3, 6'd1);
    commit(5'd5, 4'd3, 32'hDEADBEEF); tick(); idle();
    chk("commit_x5", 0, 5'd5, 32'hDEADBEEF, 1'b0, 4'd0, 6'd0);

    // Stale commit writes value but keeps the newer rename
    rename(5'd7, 4'd2); tick(); idle();
    rename(5'd7, 4'd9); tick(); idle();
    commit(5'd7, 4'd2, 32'h11); tick(); idle();
    chk("stale_commit_x7", 1, 5'd7, 32'h11, 1'b1, 4'd9, 6'd1);

    // Same-cycle rename and matching commit: rename wins
    rename(5'd4, 4'd1); tick(); idle();
    commit(5'd4, 4'd1, 32'h44); rename(5'd4, 4'd6); tick(); idle();
    chk("ren_cmt_same_x4", 0, 5'd4, 32'h44, 1'b1, 4'd6, 6'd2);

    // Flush with a dropped rename and a surviving commit value
    rename(5'd1, 4'd1); tick(); idle();
    rename(5'd2, 4'd2); tick(); idle();
    rename(5'd3, 4'd3); tick(); idle();
    flush_in = 1'b1; rename(5'd8, 4'd8); commit(5'd2, 4'd2, 32'h55); tick(); idle();
    chk("flush_x2", 0, 5'd2, 32'h55, 1'b0, 4'd0, 6'd0);
    chk("flush_x8", 1, 5'd8, 32'h0,  1'b0, 4'd0, 6'd0);
    chk("flush_x7", 0, 5'd7, 32'h11, 1'b0, 4'd0, 6'd0);

    // x0 is hardwired
    rename(5'd0, 4'd5); commit(5'd0, 4'd5, 32'h99); tick(); idle();
    chk("x0_hardwired", 1, 5'd0, 32'h0, 1'b0, 4'd0, 6'd0);

    // Stalled cycle ignores all requests
    rdy_in = 1'b0;
    rename(5'd9, 4'd3); commit(5'd2, 4'd2, 32'h77); tick(); idle();
    rdy_in = 1'b1;
    chk("stall_x9", 0, 5'd9, 32'h0,  1'b0, 4'd0, 6'd0);
    chk("stall_x2", 1, 5'd2, 32'h55, 1'b0, 4'd0, 6'd0);

    // Commit-to-read forwarding (or its absence)
    rename(5'd5, 4'd3); tick(); idle();
    chk("rebusy_x5", 0, 5'd5, 32'hDEADBEEF, 1'b1, 4'd3, 6'd1);
    commit(5'd5, 4'd3, 32'h42);
`ifdef REGFILE_BYPASS_EN
    chk("bypass_same_cycle", 0, 5'd5, 32'h42, 1'b0, 4'd3, 6'd1);
`else
    chk("no_bypass_same_cycle", 0, 5'd5, 32'hDEADBEEF, 1'b1, 4'd3, 6'd1);
`endif
    tick(); idle();
    chk("commit_x5_after", 0, 5'd5, 32'h42, 1'b0, 4'd0, 6'd0);

    // Reset mid-operation discards the pending rename
    rename(5'd10, 4'd1);
    #1 rst_in = 1'b1;
    idle();
    chk("midrst_x5", 1, 5'd5, 32'h0, 1'b0, 4'd0, 6'd0);
    rst_in = 1'b0;
    tick();
    chk("midrst_x10", 0, 5'd10, 32'h0, 1'b0, 4'd0, 6'd0);

    // Drain: every queued expectation must have been consumed
    #5;
    if (push_cnt != pop_cnt) begin
      n_checks++;
      $display("FAIL drain: got %0d popped, want %0d", pop_cnt, push_cnt);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule : tb_reg_rename_file
`default_nettype wire
